axi_burst_addr_gen: RTL and testbench

//  Per-beat address generator downstream of the axi_protocol channel FSM. Accepts

---
 rtl/axi_burst_pkg.sv | 11 +
 rtl/axi_burst_addr_gen_if.sv | 22 ++
 rtl/axi_next_addr.sv | 21 ++
 rtl/axi_burst_addr_gen.sv | 105 ++++++++++
 tb/tb_axi_burst_addr_gen.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: burst type codes, FSM states and helpers shared by the burst address generator
package axi_burst_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  function automatic logic wrap_len_ok(input int beats);
    return beats == 2 || beats == 4 || beats == 8 || beats == 16;
  endfunction
endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// axi_burst_addr_gen_if: command and beat bus of the burst address generator
//   master: drives cmd_* and beat_valid/beat_last_in; slave: drives cmd_ready, beat status and error pulses
interface axi_burst_addr_gen_if #(parameter int AW = 32, parameter int LENW = 8);
  logic cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst;
  logic beat_valid, beat_last_in;
  logic active;
  logic [AW-1:0] beat_addr;
  logic [LENW-1:0] beat_idx;
  logic beat_last, err_last, err_orphan, err_burst, err_4k;
  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_valid, beat_last_in,
    input cmd_ready, active, beat_addr, beat_idx, beat_last, err_last, err_orphan, err_burst, err_4k
  );
  modport slave (
    input cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_valid, beat_last_in,
    output cmd_ready, active, beat_addr, beat_idx, beat_last, err_last, err_orphan, err_burst, err_4k
  );
endinterface

// File: rtl/axi_next_addr.sv
// axi_next_addr: combinational next-beat address for FIXED/INCR/WRAP bursts
//   ports: addr, len, size, burst in; nxt out (modulo 2^AW)
module axi_next_addr
  import axi_burst_pkg::*;
#(parameter int AW = 32, parameter int LENW = 8) (
  input  logic [AW-1:0]   addr,
  input  logic [LENW-1:0] len,
  input  logic [2:0]      size,
  input  logic [1:0]      burst,
  output logic [AW-1:0]   nxt
);
  logic [AW-1:0] bytes, aligned, wlen, lo, inc;
  always_comb begin
    bytes = AW'(1) << size;
    aligned = addr & ~(bytes - AW'(1));
    wlen = (AW'(len) + AW'(1)) << size;
    lo = addr & ~(wlen - AW'(1));
    inc = aligned + bytes;
    nxt = burst == BURST_FIXED ? addr : (burst == BURST_WRAP && inc == lo + wlen) ? lo : inc;
  end
endmodule

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: per-beat AXI address generator with one pending command slot
//   ports: axi_aclk clock; rst async active-high reset; bus (axi_burst_addr_gen_if.slave) command/beat bus
//   AXI_4K_CHECK_EN: when defined, err_4k flags INCR bursts crossing a 4 KB page; otherwise err_4k is 0
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(parameter int AW = 32, parameter int LENW = 8) (
  input logic axi_aclk,
  input logic rst,
  axi_burst_addr_gen_if.slave bus
);
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [LENW-1:0] len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } cmd_t;
  state_t st, st_n;
  cmd_t cur, cur_n, pend, pend_n, in_cmd, src;
  logic pend_v, pend_v_n, acc, bad, last, fin, go;
  logic [AW-1:0] addr_q, addr_n, nxt;
  logic [LENW-1:0] idx_q, idx_n;
  logic e_last_q, e_orph_q, e_burst_q;
  axi_next_addr #(.AW(AW), .LENW(LENW)) u_next (
    .addr(addr_q), .len(cur.len), .size(cur.size), .burst(cur.burst), .nxt(nxt)
  );
  always_comb begin
    acc = bus.cmd_valid && !pend_v;
    bad = bus.cmd_burst == BURST_RSVD || (bus.cmd_burst == BURST_WRAP && !wrap_len_ok(int'(bus.cmd_len) + 1));
    // illegal bursts are flagged once at accept and then sequenced as INCR
    in_cmd = '{addr: bus.cmd_addr, len: bus.cmd_len, size: bus.cmd_size, burst: bad ? BURST_INCR : bus.cmd_burst};
    last = st == ST_ACTIVE && idx_q == cur.len;
    fin = bus.beat_valid && last;
    // pend_v is never set in IDLE, so src is the incoming command there
    src = pend_v ? pend : in_cmd;
    go = st == ST_IDLE ? acc : fin && (pend_v || acc);
    st_n = st;
    cur_n = cur;
    pend_n = pend;
    pend_v_n = pend_v;
    addr_n = addr_q;
    idx_n = idx_q;
    if (go) begin
      st_n = ST_ACTIVE;
      cur_n = src;
      addr_n = src.addr;
      idx_n = '0;
      pend_v_n = 1'b0;
    end else if (fin) begin
      st_n = ST_IDLE;
    end else if (st == ST_ACTIVE) begin
      if (bus.beat_valid) begin
        idx_n = idx_q + LENW'(1);
        addr_n = nxt;
      end
      if (acc) begin
        pend_n = in_cmd;
        pend_v_n = 1'b1;
      end
    end
  end
  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
      cur <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      addr_q <= '0;
      idx_q <= '0;
      e_last_q <= 1'b0;
      e_orph_q <= 1'b0;
      e_burst_q <= 1'b0;
    end else begin
      st <= st_n;
      cur <= cur_n;
      pend <= pend_n;
      pend_v <= pend_v_n;
      addr_q <= addr_n;
      idx_q <= idx_n;
      e_last_q <= bus.beat_valid && st == ST_ACTIVE && bus.beat_last_in != last;
      e_orph_q <= bus.beat_valid && st == ST_IDLE;
      e_burst_q <= acc && bad;
    end
  end
`ifdef AXI_4K_CHECK_EN
  logic [AW-1:0] span_end;
  logic e_4k_q;
  always_comb span_end = (bus.cmd_addr & ~((AW'(1) << bus.cmd_size) - AW'(1)))
                       + ((AW'(bus.cmd_len) + AW'(1)) << bus.cmd_size) - AW'(1);
  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) e_4k_q <= 1'b0;
    else e_4k_q <= acc && bus.cmd_burst == BURST_INCR && span_end[AW-1:12] != bus.cmd_addr[AW-1:12];
  end
  assign bus.err_4k = e_4k_q;
`else
  assign bus.err_4k = 1'b0;
`endif
  assign bus.cmd_ready = !pend_v;
  assign bus.active = st == ST_ACTIVE;
  assign bus.beat_addr = addr_q;
  assign bus.beat_idx = idx_q;
  assign bus.beat_last = last;
  assign bus.err_last = e_last_q;
  assign bus.err_orphan = e_orph_q;
  assign bus.err_burst = e_burst_q;
endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// tb_axi_burst_addr_gen: directed and randomized checks of axi_burst_addr_gen against a burst-list model
module tb_axi_burst_addr_gen;
  import axi_burst_pkg::*;
  typedef struct {
    logic [31:0] a;
    logic [7:0]  i;
    logic        last;
  } beat_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  beat_t beats[$];
  int outst;
  logic x_orph, x_last, x_burst, x_4k;
  logic cv_r, bv_r, bli_r;
  logic [31:0] a_r;
  int len_r, lr;
  axi_burst_addr_gen_if bus();
  axi_burst_addr_gen dut (.axi_aclk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // address of beat i derived directly from the burst's start and span, not by stepping
  function automatic logic [31:0] addr_of(input logic [31:0] a, input int len, input int size, input logic [1:0] b, input int i);
    logic [31:0] bytes, al, wlen, lo;
    bytes = 32'(1) << size;
    al = a & ~(bytes - 32'(1));
    wlen = 32'(len + 1) * bytes;
    lo = a & ~(wlen - 32'(1));
    if (i == 0 || b == BURST_FIXED) return a;
    if (b == BURST_WRAP) return lo + ((al - lo) + 32'(i) * bytes) % wlen;
    return al + 32'(i) * bytes;
  endfunction
  function automatic logic crosses_4k(input logic [31:0] a, input int len, input int size);
    logic [31:0] first, final_byte;
    first = a & ~((32'(1) << size) - 32'(1));
    final_byte = first + 32'(len + 1) * (32'(1) << size) - 32'(1);
    return final_byte[31:12] != a[31:12];
  endfunction
  task automatic check_state();
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(outst < 2));
    chk("active", 64'(bus.active), 64'(outst > 0));
    if (outst > 0 && beats.size() > 0) begin
      chk("beat_addr", 64'(bus.beat_addr), 64'(beats[0].a));
      chk("beat_idx", 64'(bus.beat_idx), 64'(beats[0].i));
      chk("beat_last", 64'(bus.beat_last), 64'(beats[0].last));
    end else begin
      chk("beat_last_idle", 64'(bus.beat_last), 64'(0));
    end
    chk("err_last", 64'(bus.err_last), 64'(x_last));
    chk("err_orphan", 64'(bus.err_orphan), 64'(x_orph));
    chk("err_burst", 64'(bus.err_burst), 64'(x_burst));
    chk("err_4k", 64'(bus.err_4k), 64'(x_4k));
  endtask
  task automatic step(input logic cv, input logic [31:0] a, input int len, input int size,
                      input logic [1:0] b, input logic bv, input logic bli);
    logic acc, illegal;
    logic [1:0] eb;
    @(negedge clk);
    check_state();
    bus.cmd_valid = cv;
    bus.cmd_addr = a;
    bus.cmd_len = 8'(len);
    bus.cmd_size = 3'(size);
    bus.cmd_burst = b;
    bus.beat_valid = bv;
    bus.beat_last_in = bli;
    acc = cv && outst < 2;
    illegal = b == BURST_RSVD || (b == BURST_WRAP && !(len inside {1, 3, 7, 15}));
    eb = illegal ? BURST_INCR : b;
    x_orph = bv && outst == 0;
    x_last = bv && outst > 0 && bli != beats[0].last;
    if (bv && outst > 0) begin
      if (beats[0].last) outst--;
      void'(beats.pop_front());
    end
    x_burst = acc && illegal;
`ifdef AXI_4K_CHECK_EN
    x_4k = acc && b == BURST_INCR && crosses_4k(a, len, size);
`else
    x_4k = 1'b0;
`endif
    if (acc) begin
      for (int i = 0; i <= len; i++) beats.push_back('{addr_of(a, len, size, eb, i), 8'(i), i == len});
      outst++;
    end
  endtask
  task automatic idle();
    step(1'b0, 32'h0, 0, 0, 2'b00, 1'b0, 1'b0);
  endtask
  task automatic beat();
    step(1'b0, 32'h0, 0, 0, 2'b00, 1'b1, outst > 0 && beats[0].last);
  endtask
  task automatic beat_with(input logic bli);
    step(1'b0, 32'h0, 0, 0, 2'b00, 1'b1, bli);
  endtask
  task automatic cmd(input logic [31:0] a, input int len, input int size, input logic [1:0] b);
    step(1'b1, a, len, size, b, 1'b0, 1'b0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.cmd_size = '0;
    bus.cmd_burst = '0;
    bus.beat_valid = 1'b0;
    bus.beat_last_in = 1'b0;
    outst = 0;
    {x_orph, x_last, x_burst, x_4k} = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    chk("reset_beat_addr", 64'(bus.beat_addr), 64'h0);
    chk("reset_beat_idx", 64'(bus.beat_idx), 64'h0);
    cmd(32'h1004, 3, 2, BURST_INCR);
    beat(); chk("incr_b0", 64'(bus.beat_addr), 64'h1004);
    beat(); chk("incr_b1", 64'(bus.beat_addr), 64'h1008);
    beat(); chk("incr_b2", 64'(bus.beat_addr), 64'h100C);
    beat(); chk("incr_b3", 64'(bus.beat_addr), 64'h1010);
    chk("incr_last_idx", 64'(bus.beat_idx), 64'h3);
    chk("incr_last", 64'(bus.beat_last), 64'h1);
    idle(); chk("incr_done", 64'(bus.active), 64'h0);
    chk("idle_hold_addr", 64'(bus.beat_addr), 64'h1010);
    cmd(32'h34, 3, 2, BURST_WRAP);
    beat(); chk("wrap_b0", 64'(bus.beat_addr), 64'h34);
    beat(); chk("wrap_b1", 64'(bus.beat_addr), 64'h38);
    beat(); chk("wrap_b2", 64'(bus.beat_addr), 64'h3C);
    beat(); chk("wrap_b3", 64'(bus.beat_addr), 64'h30);
    cmd(32'h40, 2, 2, BURST_WRAP);
    beat(); chk("wrap_bad_err", 64'(bus.err_burst), 64'h1);
    beat(); chk("wrap_bad_incr", 64'(bus.beat_addr), 64'h44);
    beat(); chk("wrap_bad_b2", 64'(bus.beat_addr), 64'h48);
    cmd(32'h100, 0, 2, BURST_INCR);
    step(1'b1, 32'h200, 1, 2, BURST_INCR, 1'b0, 1'b0);
    beat(); chk("b2b_ready_full", 64'(bus.cmd_ready), 64'h0);
    beat(); chk("b2b_active", 64'(bus.active), 64'h1);
    chk("b2b_addr", 64'(bus.beat_addr), 64'h200);
    beat(); chk("b2b_b1", 64'(bus.beat_addr), 64'h204);
    cmd(32'h280, 0, 2, BURST_INCR);
    step(1'b1, 32'h300, 1, 0, BURST_FIXED, 1'b1, 1'b1);
    beat(); chk("same_cycle_addr", 64'(bus.beat_addr), 64'h300);
    chk("same_cycle_idx", 64'(bus.beat_idx), 64'h0);
    beat(); chk("fixed_b1", 64'(bus.beat_addr), 64'h300);
    cmd(32'h500, 3, 2, BURST_INCR);
    beat_with(1'b0);
    beat_with(1'b1);
    beat_with(1'b0); chk("err_last_idx1", 64'(bus.err_last), 64'h1);
    beat_with(1'b0);
    idle(); chk("err_last_idx3", 64'(bus.err_last), 64'h1);
    beat_with(1'b0);
    idle(); chk("err_orphan", 64'(bus.err_orphan), 64'h1);
    cmd(32'h600, 3, 2, BURST_INCR);
    beat();
    beat();
    @(negedge clk);
    check_state();
    chk("pre_rst_idx", 64'(bus.beat_idx), 64'h2);
    bus.cmd_valid = 1'b0;
    bus.beat_valid = 1'b0;
    bus.beat_last_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_active", 64'(bus.active), 64'h0);
    chk("rst_ready", 64'(bus.cmd_ready), 64'h1);
    chk("rst_addr", 64'(bus.beat_addr), 64'h0);
    chk("rst_idx", 64'(bus.beat_idx), 64'h0);
    chk("rst_last", 64'(bus.beat_last), 64'h0);
    beats.delete();
    outst = 0;
    {x_orph, x_last, x_burst, x_4k} = '0;
    @(negedge clk);
    rst = 1'b0;
    cmd(32'h700, 1, 2, BURST_INCR);
    beat(); chk("post_rst_idx", 64'(bus.beat_idx), 64'h0);
    chk("post_rst_addr", 64'(bus.beat_addr), 64'h700);
    beat();
    cmd(32'hFF8, 1, 3, BURST_INCR);
`ifdef AXI_4K_CHECK_EN
    beat(); chk("err_4k_cross", 64'(bus.err_4k), 64'h1);
`else
    beat(); chk("err_4k_off", 64'(bus.err_4k), 64'h0);
`endif
    beat();
    for (int n = 0; n < 800; n++) begin
      lr = int'($urandom_range(0, 8));
      len_r = lr == 8 ? 15 : lr;
      a_r = $urandom;
      cv_r = $urandom_range(0, 2) == 0;
      bv_r = $urandom_range(0, 2) != 0;
      bli_r = outst > 0 && beats[0].last;
      if ($urandom_range(0, 15) == 0) bli_r = !bli_r;
      step(cv_r, a_r, len_r, int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), bv_r, bli_r);
    end
    for (int n = 0; n < 200 && outst > 0; n++) beat();
    idle();
    chk("drain_done", 64'(outst), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
